// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debounce_pkg
// Brief    : Shared FSM encoding and timing constants for button_debouncer.
// Revision : 1.0
// ============================================================================
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    localparam int c_clk_hz                  = 12_000_000;
    localparam int c_debounce_window_ms      = 10;
    localparam int c_default_debounce_cycles = (c_clk_hz / 1000) * c_debounce_window_ms;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/button_debouncer_sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : sync_chain
// Brief    : STAGES-deep flop synchroniser for one asynchronous bit.
// Revision : 1.0
// ============================================================================
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Brief    : Synchronises and debounces a raw button; registered level plus
//            one-cycle rise/fall pulses. BUTTON_DEBOUNCER_TOGGLE_EN adds a
//            T flip-flop output (toggle_out) driven by rise_pulse.
// Revision : 1.0
// ============================================================================
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
   ,output logic toggle_out
`endif
);

    localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic             w_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk (clk),
        .rst (rst),
        .i_d (btn_in),
        .o_q (w_s)
    );

    // The first departing sample counts as 1, so acceptance lands on the
    // DEBOUNCE_CYCLES-th consecutive departing sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                STABLE_LO: begin
                    if (w_s) begin
                        r_state <= CHK_HI;
                        r_cnt   <= c_cnt_one;
                    end
                end
                CHK_HI: begin
                    if (!w_s) begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                STABLE_HI: begin
                    if (!w_s) begin
                        r_state <= CHK_LO;
                        r_cnt   <= c_cnt_one;
                    end
                end
                CHK_LO: begin
                    if (w_s) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= STABLE_LO;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign level_out  = r_level;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;

`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
    logic r_toggle;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_toggle <= 1'b0;
        end else if (r_rise) begin
            r_toggle <= ~r_toggle;
        end
    end

    assign toggle_out = r_toggle;
`endif

endmodule : button_debouncer
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debouncer
// Brief    : Self-checking bench: directed scenarios plus random button
//            activity against a sliding-window reference model.
// Revision : 1.0
// ============================================================================
module tb_button_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic level_out;
    logic rise_pulse;
    logic fall_pulse;
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
    logic toggle_out;
`endif

    always #5 clk = ~clk;

    button_debouncer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
       ,.toggle_out (toggle_out)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the level flips once the last DEB synchronised
    // samples all disagree with it; s is btn_in delayed by SYNC edges.
    bit pipe[$];
    bit hist[$];
    bit m_level, m_rise, m_fall, m_tog;

    task automatic model_edge(input bit b, input bit r);
        bit s;
        bit all_diff;
        if (r) begin
            pipe.delete();
            hist.delete();
            for (int i = 0; i < SYNC; i++) pipe.push_back(1'b0);
            m_level = 1'b0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            m_tog   = 1'b0;
        end else begin
            if (m_rise) m_tog = ~m_tog;
            s = pipe.pop_front();
            pipe.push_back(b);
            hist.push_back(s);
            if (hist.size() > DEB) void'(hist.pop_front());
            m_rise = 1'b0;
            m_fall = 1'b0;
            all_diff = (hist.size() == DEB);
            foreach (hist[i]) if (hist[i] == m_level) all_diff = 1'b0;
            if (all_diff) begin
                m_level = ~m_level;
                if (m_level) m_rise = 1'b1;
                else         m_fall = 1'b1;
            end
        end
    endtask

    int   edge_cnt;
    int   rise_edge;
    int   fall_edge;
    int   n_rise;
    int   tog_edge;
    logic prev_pulse = 1'b0;
    logic prev_tog   = 1'b0;

    task automatic mark();
        edge_cnt  = 0;
        rise_edge = -1;
        fall_edge = -1;
        n_rise    = 0;
        tog_edge  = -1;
    endtask

    task automatic step(input bit b, input bit r);
        btn_in = b;
        rst    = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
        edge_cnt++;
        if (rise_pulse === 1'b1) begin
            rise_edge = edge_cnt;
            n_rise++;
        end
        if (fall_pulse === 1'b1) fall_edge = edge_cnt;
        check("level", level_out, m_level);
        check("rise", rise_pulse, m_rise);
        check("fall", fall_pulse, m_fall);
        check("excl", rise_pulse & fall_pulse, 1'b0);
        check("consec", prev_pulse & (rise_pulse | fall_pulse), 1'b0);
        prev_pulse = rise_pulse | fall_pulse;
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
        check("toggle", toggle_out, m_tog);
        if (toggle_out !== prev_tog) tog_edge = edge_cnt;
        prev_tog = toggle_out;
`endif
    endtask

    initial begin
        btn_in = 1'b0;
        rst    = 1'b1;
        mark();

        // Reset held with button pressed, then released
        repeat (3) step(1'b1, 1'b1);
        check("rst_level", level_out, 1'b0);
        check("rst_rise", rise_pulse, 1'b0);
        mark();
        repeat (6) step(1'b1, 1'b0);
        check("rst_rise_edge", rise_edge, 6);
        check("rst_level_on", level_out, 1'b1);
        step(1'b1, 1'b0);
        check("rst_rise_once", rise_pulse, 1'b0);

        // Clean release, press, release
        mark();
        repeat (20) step(1'b0, 1'b0);
        check("rel0_fall_edge", fall_edge, 6);
        mark();
        repeat (20) step(1'b1, 1'b0);
        check("press_rise_edge", rise_edge, 6);
        check("press_rise_count", n_rise, 1);
        check("press_level", level_out, 1'b1);
        mark();
        repeat (20) step(1'b0, 1'b0);
        check("rel_fall_edge", fall_edge, 6);
        check("rel_level", level_out, 1'b0);

        // Bounce shorter than the window
        mark();
        repeat (5) begin
            step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        end
        repeat (10) step(1'b0, 1'b0);
        check("bounce_rise", rise_edge, -1);
        check("bounce_fall", fall_edge, -1);
        check("bounce_level", level_out, 1'b0);

        // Bounce then settle high
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        mark();
        repeat (12) step(1'b1, 1'b0);
        check("settle_rise_edge", rise_edge, 6);
        check("settle_rise_count", n_rise, 1);

        // Reset in the middle of a check
        repeat (20) step(1'b0, 1'b0);
        mark();
        repeat (4) step(1'b1, 1'b0);
        check("midrst_no_rise", rise_edge, -1);
        step(1'b1, 1'b1);
        mark();
        repeat (12) step(1'b1, 1'b0);
        check("midrst_rise_edge", rise_edge, 6);
        check("midrst_rise_count", n_rise, 1);

`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
        begin
            logic [2:0] exp_tog;
            exp_tog = 3'b101;
            step(1'b0, 1'b1);
            repeat (10) step(1'b0, 1'b0);
            for (int p = 0; p < 3; p++) begin
                mark();
                repeat (12) step(1'b1, 1'b0);
                check("tog_value", toggle_out, exp_tog[p]);
                check("tog_after_rise", tog_edge, rise_edge + 1);
                repeat (12) step(1'b0, 1'b0);
            end
        end
`endif

        // Random button activity with occasional resets
        for (int seg = 0; seg < 150; seg++) begin
            bit b;
            int len;
            b   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++) begin
                step(b, ($urandom_range(0, 59) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_button_debouncer
`default_nettype wire
